key_repeat_ctrl: RTL and testbench
==================================

Name: key_repeat_ctrl

Overview:
- Conditions the four raw push-button inputs into per-frame key events for the grid/game controller.
- Per key: 2-FF synchroniser, counter debounce, press/auto-repeat state machine, and a pending-event latch.
- The latch holds each event until the game consumes it at the frame boundary (draw_finish).
- Sits between the board buttons and the grid controller's op_keys input, in the vga_clk (25 MHz) domain.

Parameters:
DEBOUNCE_CYCLES, 250000, consecutive stable cycles needed to accept a level change (10 ms @ 25 MHz)
REPEAT_DELAY, 6250000, cycles from first press event to first auto-repeat event (250 ms)
REPEAT_RATE, 2500000, cycles between subsequent auto-repeat events (100 ms)
REPEAT_MASK, 4'b1110, per-key auto-repeat enable; bit0=up (rotate, no repeat), bit1=down, bit2=left, bit3=right
CNT_W, 24, width of the debounce and repeat counters; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE)

Ports:
vga_clk  input  1  25 MHz system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
key_sw  input  4  raw buttons, active-high, asynchronous; [0]=up [1]=down [2]=left [3]=right
draw_finish  input  1  one-cycle pulse at end of frame; consumes all pending events
op_keys  output  4  pending key events, same bit order; high until consumed
key_level  output  4  debounced key levels

Behaviour:
- Reset is synchronous and active-high. It clears the synchronisers, debounce counters, FSMs, op_keys=0 and key_level=0. Reset mid-hold returns the key to IDLE.
- After reset, a key already held produces a press event once it has debounced, exactly as a fresh press would.
- Synchroniser: two flops per bit; sample s = second stage.
- Debounce, per key:
  - If s != key_level, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1, key_level <= s and the counter clears.
  - Any cycle with s == key_level clears the counter.
  - Latency: a clean edge on key_sw at cycle 0 reaches key_level at cycle 2+DEBOUNCE_CYCLES.
- Repeat FSM, per key: states IDLE, DELAY, REPEAT.
  - IDLE: when key_level is 1, emit an event and go to DELAY with the timer cleared. If the key's REPEAT_MASK bit is 0, stay in IDLE-HELD instead (no further events until release).
  - DELAY: the timer counts. When it reaches REPEAT_DELAY-1, emit an event, clear the timer, go to REPEAT.
  - REPEAT: when the timer reaches REPEAT_RATE-1, emit an event and clear the timer.
  - Any state: key_level = 0 sends the FSM to IDLE and clears the timer, with no event.
  - The event is registered, so op_keys rises one cycle after the key_level rise.
- Pending latch: op_keys[i] <= (op_keys[i] & ~draw_finish) | event[i].
  - An event coinciding with draw_finish is kept (set wins).
  - Multiple events before one draw_finish collapse into a single pending bit. No counting, no overflow.
- Keys are fully independent; simultaneous presses produce simultaneous op_keys bits.
- A bounce shorter than DEBOUNCE_CYCLES produces no key_level change and no event.

Optional Feature:
KEY_OPPOSITE_LOCK_EN
- Defined: while key_level[2] and key_level[3] are both 1, left/right events are suppressed.
  - Their FSMs are held in IDLE, so releasing one key lets the other produce a fresh press event on the next cycle.
  - Already-pending op_keys bits are unaffected.
- Undefined: left and right are independent like all other keys.

Test Plan:
Run all scenarios with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8, draw_finish low unless stated.
1. Clean press: key_sw[2]=1 at cycle 0, held.
   -> key_level[2]=1 at cycle 6; op_keys[2]=1 at cycle 7; draw_finish at cycle 10 -> op_keys[2]=0 at cycle 11.
2. Bounce: key_sw[1] high for 3 cycles, then low.
   -> key_level and op_keys stay 0.
3. Auto-repeat: hold key_sw[3], pulsing draw_finish every cycle.
   -> events at cycles 7, 27, 35, 43.
   Release -> no further events; FSM returns to IDLE.
4. No repeat on up: hold key_sw[0] for 100 cycles with draw_finish every cycle.
   -> exactly one event, at cycle 7.
5. Collision: event and draw_finish in the same cycle.
   -> op_keys bit is still 1 the next cycle.
   Reset asserted while holding down -> all outputs 0 next cycle; event reappears 7 cycles after reset deasserts.
6. With KEY_OPPOSITE_LOCK_EN: hold left and right together.
   -> no left/right events.
   Release right -> left event follows on the next cycle.
   Without the macro -> both events at cycle 7.

Source files
------------

// File: rtl/key_repeat_if.sv
// Button-side bundle for key_repeat_ctrl: raw buttons and frame strobe in,
// pending key events, debounced levels and per-key FSM debug state out.
interface key_repeat_if;
  // draw_finish is a one-cycle consume strobe with no back-pressure: each
  // op_keys bit stays high from its event until a cycle where draw_finish is
  // high and no new event for that key arrives in the same cycle.
  logic [3:0] key_sw;
  logic       draw_finish;
  logic [3:0] op_keys;
  logic [3:0] key_level;
  logic [7:0] dbg_state;

  modport master (
    output key_sw,
    output draw_finish,
    input  op_keys,
    input  key_level,
    input  dbg_state
  );

  modport slave (
    input  key_sw,
    input  draw_finish,
    output op_keys,
    output key_level,
    output dbg_state
  );
endinterface

// File: rtl/key_repeat_ctrl.sv
// Four-key button conditioner: 2-FF sync, counter debounce, press/auto-repeat FSM
// and pending-event latch. Optional macro KEY_OPPOSITE_LOCK_EN suppresses left/right while both are held.
module key_repeat_ctrl #(
  parameter int         DEBOUNCE_CYCLES = 250000,
  parameter int         REPEAT_DELAY    = 6250000,
  parameter int         REPEAT_RATE     = 2500000,
  parameter logic [3:0] REPEAT_MASK     = 4'b1110,
  parameter int         CNT_W           = 24
) (
  input logic          vga_clk,
  input logic          reset,
  key_repeat_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2,
    HELD   = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RR_LAST = CNT_W'(REPEAT_RATE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [3:0]       sync1_q, sync1_d;
  logic [3:0]       sync2_q, sync2_d;
  logic [3:0]       level_q, level_d;
  logic [3:0]       op_keys_q, op_keys_d;
  logic [CNT_W-1:0] db_cnt_q [4];
  logic [CNT_W-1:0] db_cnt_d [4];
  logic [CNT_W-1:0] tmr_q [4];
  logic [CNT_W-1:0] tmr_d [4];
  state_e           state_q [4];
  state_e           state_d [4];
  logic [3:0]       key_event;
  logic [3:0]       lock_mask;

`ifdef KEY_OPPOSITE_LOCK_EN
  assign lock_mask = {2{level_q[2] & level_q[3]}} & 4'b1100;
`else
  assign lock_mask = 4'b0000;
`endif

  always_comb begin
    sync1_d   = bus.key_sw;
    sync2_d   = sync1_q;
    level_d   = level_q;
    db_cnt_d  = db_cnt_q;
    tmr_d     = tmr_q;
    state_d   = state_q;
    key_event = 4'b0000;

    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          level_d[i]  = sync2_q[i];
          db_cnt_d[i] = '0;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + CNT_ONE;
        end
      end else begin
        db_cnt_d[i] = '0;
      end

      // A released or locked key always restarts from IDLE, so re-eligibility is a fresh press.
      if (!level_q[i] || lock_mask[i]) begin
        state_d[i] = IDLE;
        tmr_d[i]   = '0;
      end else begin
        case (state_q[i])
          IDLE: begin
            key_event[i] = 1'b1;
            tmr_d[i]     = '0;
            state_d[i]   = REPEAT_MASK[i] ? DELAY : HELD;
          end
          DELAY: begin
            if (tmr_q[i] == RD_LAST) begin
              key_event[i] = 1'b1;
              tmr_d[i]     = '0;
              state_d[i]   = REPEAT;
            end else begin
              tmr_d[i] = tmr_q[i] + CNT_ONE;
            end
          end
          REPEAT: begin
            if (tmr_q[i] == RR_LAST) begin
              key_event[i] = 1'b1;
              tmr_d[i]     = '0;
            end else begin
              tmr_d[i] = tmr_q[i] + CNT_ONE;
            end
          end
          default: begin
            state_d[i] = HELD;
          end
        endcase
      end
    end

    // Set wins over consume so an event landing on the frame strobe is not lost.
    op_keys_d = (op_keys_q & ~{4{bus.draw_finish}}) | key_event;
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      level_q   <= '0;
      op_keys_q <= '0;
      for (int i = 0; i < 4; i++) begin
        db_cnt_q[i] <= '0;
        tmr_q[i]    <= '0;
        state_q[i]  <= IDLE;
      end
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      level_q   <= level_d;
      op_keys_q <= op_keys_d;
      db_cnt_q  <= db_cnt_d;
      tmr_q     <= tmr_d;
      state_q   <= state_d;
    end
  end

  assign bus.op_keys   = op_keys_q;
  assign bus.key_level = level_q;
  assign bus.dbg_state = {state_q[3], state_q[2], state_q[1], state_q[0]};

endmodule

// File: tb/tb_key_repeat_ctrl.sv
// Bench for key_repeat_ctrl with short timing parameters: vector table,
// hand-written corner sequences and randomized run against a time-based model.
module tb_key_repeat_ctrl;

  localparam int         D    = 4;
  localparam int         RD   = 20;
  localparam int         RR   = 8;
  localparam logic [3:0] MASK = 4'b1110;

  logic clk;
  logic rst;
  int   cyc;
  int   n_tests;
  int   n_fail;

  key_repeat_if kif ();

  key_repeat_ctrl #(
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (RD),
    .REPEAT_RATE     (RR),
    .REPEAT_MASK     (MASK),
    .CNT_W           (24)
  ) dut (
    .vga_clk (clk),
    .reset   (rst),
    .bus     (kif)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Debounce: level flips once the last D synchronised samples all disagree with it.
  // Events: derived from how long a key has been continuously eligible (held, unlocked).
  logic [3:0]  m_sw1, m_sw2, m_lvl, m_op;
  logic [15:0] m_hist [4];
  int          m_run [4];

  task automatic model_edge(input logic r, input logic [3:0] sw, input logic df);
    logic [3:0] s;
    logic [3:0] ev;
    logic [3:0] nl;
    logic       lock;
    logic       elig;
    logic [15:0] dmask;
    if (r) begin
      m_sw1 = '0; m_sw2 = '0; m_lvl = '0; m_op = '0;
      for (int i = 0; i < 4; i++) begin
        m_hist[i] = '0;
        m_run[i]  = 0;
      end
      return;
    end
    s = m_sw2;
    dmask = 16'((1 << D) - 1);
`ifdef KEY_OPPOSITE_LOCK_EN
    lock = m_lvl[2] & m_lvl[3];
`else
    lock = 1'b0;
`endif
    nl = m_lvl;
    for (int i = 0; i < 4; i++) begin
      elig = m_lvl[i] && !(lock && i >= 2);
      ev[i] = elig && (m_run[i] == 0 ||
              (MASK[i] && m_run[i] >= RD && ((m_run[i] - RD) % RR) == 0));
      m_run[i] = elig ? m_run[i] + 1 : 0;
      m_hist[i] = {m_hist[i][14:0], s[i]};
      if ((m_hist[i] & dmask) == (m_lvl[i] ? 16'h0 : dmask)) nl[i] = s[i];
    end
    m_lvl = nl;
    m_op  = (m_op & ~{4{df}}) | ev;
    m_sw2 = m_sw1;
    m_sw1 = sw;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    logic [3:0] sw;
    logic       df;
    logic       r;
    sw = kif.key_sw;
    df = kif.draw_finish;
    r  = rst;
    @(posedge clk);
    model_edge(r, sw, df);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    kif.key_sw = 4'b0000;
    kif.draw_finish = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 25)
        $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0] sw;
    logic       df;
    int         n;
    logic [3:0] exp_op;
    logic [3:0] exp_lvl;
  } vec_t;

  vec_t vecs [9];
  logic [31:0] exp_q [$];

  initial begin
    logic [1:0] acc;
    int         ev_cnt;
    int         ev_first;
    logic [3:0] sw;

    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    rst     = 1'b1;
    kif.key_sw = 4'b0000;
    kif.draw_finish = 1'b0;

    vecs[0] = '{4'b0001, 1'b0, 10, 4'b0001, 4'b0001};
    vecs[1] = '{4'b0001, 1'b1,  1, 4'b0000, 4'b0001};
    vecs[2] = '{4'b0011, 1'b0, 10, 4'b0010, 4'b0011};
    vecs[3] = '{4'b0011, 1'b1,  1, 4'b0000, 4'b0011};
    vecs[4] = '{4'b0000, 1'b0, 10, 4'b0000, 4'b0000};
`ifdef KEY_OPPOSITE_LOCK_EN
    vecs[5] = '{4'b1100, 1'b0, 10, 4'b0000, 4'b1100};
    vecs[6] = '{4'b1100, 1'b1,  1, 4'b0000, 4'b1100};
    vecs[7] = '{4'b1000, 1'b0, 10, 4'b1000, 4'b1000};
`else
    vecs[5] = '{4'b1100, 1'b0, 10, 4'b1100, 4'b1100};
    vecs[6] = '{4'b1100, 1'b1,  1, 4'b0000, 4'b1100};
    vecs[7] = '{4'b1000, 1'b0, 10, 4'b0000, 4'b1000};
`endif
    vecs[8] = '{4'b0000, 1'b1, 10, 4'b0000, 4'b0000};

    do_reset();
    chk("reset_op_keys", 32'(kif.op_keys), 32'h0);
    chk("reset_key_level", 32'(kif.key_level), 32'h0);
    chk("reset_fsm_idle", 32'(kif.dbg_state), 32'h0);

    for (int v = 0; v < 9; v++) begin
      kif.key_sw = vecs[v].sw;
      kif.draw_finish = vecs[v].df;
      repeat (vecs[v].n) step();
      chk($sformatf("vec%0d_op_keys", v), 32'(kif.op_keys), 32'(vecs[v].exp_op));
      chk($sformatf("vec%0d_key_level", v), 32'(kif.key_level), 32'(vecs[v].exp_lvl));
    end
    kif.draw_finish = 1'b0;

    // 1. clean press on left
    do_reset();
    kif.key_sw = 4'b0100;
    repeat (5) step();
    chk("press_level_c5", 32'(kif.key_level[2]), 32'h0);
    step();
    chk("press_level_c6", 32'(kif.key_level[2]), 32'h1);
    chk("press_op_c6", 32'(kif.op_keys[2]), 32'h0);
    step();
    chk("press_op_c7", 32'(kif.op_keys[2]), 32'h1);
    repeat (3) step();
    chk("press_op_c10", 32'(kif.op_keys[2]), 32'h1);
    kif.draw_finish = 1'b1;
    step();
    kif.draw_finish = 1'b0;
    chk("press_consumed_c11", 32'(kif.op_keys[2]), 32'h0);

    // 2. bounce shorter than the debounce window
    do_reset();
    acc = 2'b00;
    kif.key_sw = 4'b0010;
    for (int c = 1; c <= 20; c++) begin
      if (c == 4) kif.key_sw = 4'b0000;
      step();
      acc = acc | {kif.op_keys[1], kif.key_level[1]};
    end
    chk("bounce_no_change", 32'(acc), 32'h0);

    // 3. auto-repeat on right with draw_finish every cycle
    do_reset();
    exp_q = '{32'd7, 32'd27, 32'd35, 32'd43};
    kif.key_sw = 4'b1000;
    kif.draw_finish = 1'b1;
    for (int c = 1; c <= 70; c++) begin
      if (c == 45) kif.key_sw = 4'b0000;
      step();
      if (kif.op_keys[3]) begin
        if (exp_q.size() == 0) chk("repeat_unexpected_event", 32'(cyc), 32'h0);
        else chk("repeat_event_cycle", 32'(cyc), exp_q.pop_front());
      end
    end
    chk("repeat_missing_events", 32'(exp_q.size()), 32'h0);
    chk("repeat_fsm_idle", 32'(kif.dbg_state[7:6]), 32'h0);
    kif.draw_finish = 1'b0;

    // 4. up key never repeats
    do_reset();
    ev_cnt = 0;
    ev_first = -1;
    kif.key_sw = 4'b0001;
    kif.draw_finish = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      step();
      if (kif.op_keys[0]) begin
        ev_cnt++;
        if (ev_first < 0) ev_first = cyc;
      end
    end
    chk("up_event_count", 32'(ev_cnt), 32'd1);
    chk("up_event_cycle", 32'(ev_first), 32'd7);
    kif.draw_finish = 1'b0;

    // 5. event coinciding with draw_finish, then reset mid-hold
    do_reset();
    kif.key_sw = 4'b0010;
    repeat (6) step();
    chk("collide_op_c6", 32'(kif.op_keys[1]), 32'h0);
    kif.draw_finish = 1'b1;
    step();
    kif.draw_finish = 1'b0;
    chk("collide_set_wins", 32'(kif.op_keys[1]), 32'h1);
    step();
    chk("collide_still_pending", 32'(kif.op_keys[1]), 32'h1);
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midhold_reset_op", 32'(kif.op_keys), 32'h0);
    chk("midhold_reset_level", 32'(kif.key_level), 32'h0);
    cyc = 0;
    repeat (6) step();
    chk("rehold_op_c6", 32'(kif.op_keys[1]), 32'h0);
    step();
    chk("rehold_op_c7", 32'(kif.op_keys[1]), 32'h1);

    // 6. left and right held together
    do_reset();
    kif.key_sw = 4'b1100;
    repeat (6) step();
    chk("lr_op_c6", 32'(kif.op_keys), 32'h0);
    step();
`ifdef KEY_OPPOSITE_LOCK_EN
    chk("lr_locked_c7", 32'(kif.op_keys), 32'h0);
    repeat (8) step();
    chk("lr_locked_c15", 32'(kif.op_keys), 32'h0);
    kif.key_sw = 4'b0100;
    repeat (6) step();
    chk("lr_release_c21", 32'(kif.op_keys), 32'h0);
    step();
    chk("lr_release_c22", 32'(kif.op_keys), 32'b0100);
`else
    chk("lr_both_c7", 32'(kif.op_keys), 32'b1100);
`endif

    // randomized run against the reference model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      sw = kif.key_sw;
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 29) == 0) sw[i] = ~sw[i];
      kif.key_sw = sw;
      kif.draw_finish = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 599) == 0);
      step();
      chk("rand_op_keys", 32'(kif.op_keys), 32'(m_op));
      chk("rand_key_level", 32'(kif.key_level), 32'(m_lvl));
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
